// File: rtl/stream_block_transposer.sv
// Streaming ELEMS x ELEMS block transposer: ELEMS input rows fill one bank of a ping-pong pair
// while the other bank is replayed column by column on the output.
module stream_block_transposer #(
  parameter int DATA_SIZE = 64,
  parameter int ELEMS     = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [ELEMS*DATA_SIZE-1:0] in,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic [ELEMS*DATA_SIZE-1:0] out,
  output logic                       out_valid,
  output logic                       out_last,
  output logic                       busy,
  output logic                       framing_err,
  output logic [0:0]                 state_dbg
);

  localparam int W  = $clog2(ELEMS);
  localparam int BW = ELEMS * DATA_SIZE;
  localparam logic [W-1:0] LAST_IDX = W'(ELEMS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  // Handshake: no ready anywhere. An input beat is taken on every edge where in_valid=1,
  // and an output beat is delivered on every edge where out_valid=1.

  logic [BW-1:0] mem [2][ELEMS];
  logic [W-1:0]  wcnt, rcnt, nxt_rcnt, ld_col;
  logic          wbank, rbank, ld_bank, ld;
  logic [1:0]    full, full_nxt, last_f;
  logic [0:0]    state, nxt_state;
  logic          wr_close, rd_done;
  logic [BW-1:0] col;

  assign wr_close  = in_valid && ((wcnt == LAST_IDX) || in_last);
  assign rd_done   = (state == S_EMIT) && (rcnt == LAST_IDX);
  assign busy      = (|full) || (state == S_EMIT) || (wcnt != '0);
  assign state_dbg = state;

  // Row storage; an early in_last zero-fills the rows that will never arrive.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int r = 0; r < ELEMS; r++) begin
        if (r == int'(wcnt))
          mem[wbank][r] <= in;
        else if (in_last && (r > int'(wcnt)))
          mem[wbank][r] <= '0;
      end
    end
  end

  always_comb begin
    full_nxt = full;
    if (wr_close) full_nxt[wbank] = 1'b1;
    // Clear applied last so it wins when both hit the same bank.
    if (rd_done)  full_nxt[rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wcnt        <= '0;
      wbank       <= 1'b0;
      full        <= '0;
      last_f      <= '0;
      framing_err <= 1'b0;
    end else begin
      full <= full_nxt;
      if (in_valid) begin
        if (wr_close) begin
          wcnt          <= '0;
          wbank         <= ~wbank;
          last_f[wbank] <= in_last;
          if (in_last && (wcnt != LAST_IDX)) framing_err <= 1'b1;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
    end
  end

  // Decide which column is registered onto out at the coming edge; rcnt names the beat on out.
  always_comb begin
    ld        = 1'b0;
    ld_bank   = rbank;
    ld_col    = '0;
    nxt_state = state;
    nxt_rcnt  = rcnt;
    case (state)
      S_IDLE: begin
        if (full[rbank]) begin
          ld        = 1'b1;
          nxt_state = S_EMIT;
          nxt_rcnt  = '0;
        end
      end
      default: begin
        if (!rd_done) begin
          ld       = 1'b1;
          ld_col   = rcnt + 1'b1;
          nxt_rcnt = rcnt + 1'b1;
        end else if (full[~rbank]) begin
          ld       = 1'b1;
          ld_bank  = ~rbank;
          nxt_rcnt = '0;
        end else begin
          nxt_state = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    col = '0;
    for (int r = 0; r < ELEMS; r++)
      col[r*DATA_SIZE +: DATA_SIZE] = mem[ld_bank][r][ld_col*DATA_SIZE +: DATA_SIZE];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      rcnt      <= '0;
      rbank     <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= nxt_state;
      rcnt      <= nxt_rcnt;
      if (rd_done) rbank <= ~rbank;
      out_valid <= ld;
      out       <= ld ? col : '0;
      out_last  <= ld && (nxt_rcnt == LAST_IDX) && last_f[ld_bank];
    end
  end

  a_no_overwrite: assert property (@(posedge clk) disable iff (!rstn)
    in_valid |-> !(full[wbank] && !(rd_done && (rbank == wbank))));

  a_no_collide: assert property (@(posedge clk) disable iff (!rstn)
    !(wr_close && rd_done && (wbank == rbank)));

endmodule

// File: tb/tb_stream_block_transposer.sv
// Directed and randomised checks of stream_block_transposer: a 4x4 byte instance for the
// hand-computed cases and an 8x8 64-bit instance against a transposing scoreboard.
module tb_stream_block_transposer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Small instance
  logic [31:0] in_a = '0, out_a;
  logic        vld_a = 1'b0, last_a = 1'b0;
  logic        out_valid_a, out_last_a, busy_a, ferr_a;
  logic [0:0]  st_a;

  stream_block_transposer #(.DATA_SIZE(8), .ELEMS(4)) dut_a (
    .clk(clk), .rstn(rstn), .in(in_a), .in_valid(vld_a), .in_last(last_a),
    .out(out_a), .out_valid(out_valid_a), .out_last(out_last_a),
    .busy(busy_a), .framing_err(ferr_a), .state_dbg(st_a)
  );

  // Full-size instance
  logic [511:0] in_b = '0, out_b;
  logic         vld_b = 1'b0, last_b = 1'b0;
  logic         out_valid_b, out_last_b, busy_b, ferr_b;
  logic [0:0]   st_b;

  stream_block_transposer #(.DATA_SIZE(64), .ELEMS(8)) dut_b (
    .clk(clk), .rstn(rstn), .in(in_b), .in_valid(vld_b), .in_last(last_b),
    .out(out_b), .out_valid(out_valid_b), .out_last(out_last_b),
    .busy(busy_b), .framing_err(ferr_b), .state_dbg(st_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Hand-computed blocks: element(r,c) = 8'h{r}{c}, 8'h{r+4}{c}, 8'h{r+8}{c}
  logic [31:0] rows_t [12] = '{
    32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130,
    32'h43424140, 32'h53525150, 32'h63626160, 32'h73727170,
    32'h83828180, 32'h93929190, 32'hA3A2A1A0, 32'hB3B2B1B0};
  logic [31:0] cols_t [12] = '{
    32'h30201000, 32'h31211101, 32'h32221202, 32'h33231303,
    32'h70605040, 32'h71615141, 32'h72625242, 32'h73635343,
    32'hB0A09080, 32'hB1A19181, 32'hB2A29282, 32'hB3A39383};

  logic [31:0]  exp_q[$];
  logic         exp_last_q[$];
  logic [511:0] exp_b_q[$];
  logic         exp_b_last_q[$];
  int           cap3;
  int           first_cyc;
  bit           mon_b = 1'b0;

  task automatic push_cols(input int base, input int n, input int last_on);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(cols_t[base+i]);
      exp_last_q.push_back(i == last_on);
    end
  endtask

  task automatic push_one(input logic [31:0] d, input logic l);
    exp_q.push_back(d);
    exp_last_q.push_back(l);
  endtask

  task automatic send_rows(input int base, input int n, input int last_at, input int bubble);
    for (int i = 0; i < n; i++) begin
      in_a   = rows_t[base+i];
      vld_a  = 1'b1;
      last_a = (i == last_at);
      @(posedge clk); #1;
      if (i % 4 == 3) cap3 = cyc;
      vld_a  = 1'b0;
      last_a = 1'b0;
      in_a   = '0;
      repeat (bubble) begin @(posedge clk); #1; end
    end
  endtask

  // Beats after the first must appear on consecutive cycles.
  task automatic receive(input int n);
    int waited;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        waited = 0;
        while (!out_valid_a && waited < 40) begin
          @(posedge clk); #1;
          waited++;
        end
        first_cyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
      check("a_valid", out_valid_a, 1'b1);
      if (exp_q.size() == 0) begin
        check("a_exp_empty", 1, 0);
      end else begin
        check("a_data", out_a, exp_q.pop_front());
        check("a_last", out_last_a, exp_last_q.pop_front());
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, "_valid"}, out_valid_a, 1'b0);
    check({tag, "_out"}, out_a, '0);
    check({tag, "_busy"}, busy_a, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_b) begin
      if (out_valid_b) begin
        if (exp_b_q.size() == 0) begin
          check("b_extra", 1, 0);
        end else begin
          check("b_data", out_b, exp_b_q.pop_front());
          check("b_last", out_last_b, exp_b_last_q.pop_front());
        end
      end else begin
        check("b_zero", out_b, '0);
      end
    end
  end

  initial begin
    logic [511:0] rows_b [8];
    logic [511:0] colv;
    int gap;
    int waited;

    // Reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out_a, '0);
    check("rst_valid", out_valid_a, 1'b0);
    check("rst_last", out_last_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_ferr", ferr_a, 1'b0);
    check("rst_b_valid", out_valid_b, 1'b0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: single block, continuous valid
    push_cols(0, 4, 3);
    fork
      begin
        send_rows(0, 4, 3, 0);
        check("t1_busy_full", busy_a, 1'b1);
        check("t1_not_yet", out_valid_a, 1'b0);
      end
      receive(4);
    join
    check("t1_latency", first_cyc, cap3 + 1);
    idle_check("t1_idle");

    // 2: three back-to-back blocks, only the last one flagged
    push_cols(0, 12, 11);
    fork
      send_rows(0, 12, 11, 0);
      receive(12);
    join
    idle_check("t2_idle");

    // 3: one bubble after every beat
    push_cols(0, 4, 3);
    fork
      send_rows(0, 4, 3, 1);
      receive(4);
    join
    check("t3_latency", first_cyc, cap3 + 1);
    check("t3_ferr", ferr_a, 1'b0);
    idle_check("t3_idle");

    // 4: in_last on beat 1 closes the block early
    push_one(32'h00001000, 1'b0);
    push_one(32'h00001101, 1'b0);
    push_one(32'h00001202, 1'b0);
    push_one(32'h00001303, 1'b1);
    fork
      send_rows(0, 2, 1, 0);
      receive(4);
    join
    check("t4_ferr", ferr_a, 1'b1);
    idle_check("t4_idle");

    // 5: reset while output beat 2 is on the port, then a fresh block
    push_cols(4, 3, -1);
    fork
      send_rows(4, 4, 3, 0);
      receive(3);
    join
    rstn = 1'b0;
    @(posedge clk); #1;
    check("t5_valid", out_valid_a, 1'b0);
    check("t5_out", out_a, '0);
    check("t5_last", out_last_a, 1'b0);
    check("t5_busy", busy_a, 1'b0);
    check("t5_ferr", ferr_a, 1'b0);
    rstn = 1'b1;
    @(posedge clk); #1;
    push_cols(8, 4, 3);
    fork
      send_rows(8, 4, 3, 0);
      receive(4);
    join
    idle_check("t5_idle");

    // 6: random 8x8 blocks with random gaps against the scoreboard
    mon_b = 1'b1;
    for (int b = 0; b < 100; b++) begin
      for (int r = 0; r < 8; r++)
        for (int w = 0; w < 16; w++)
          rows_b[r][w*32 +: 32] = $urandom;
      for (int c = 0; c < 8; c++) begin
        for (int r = 0; r < 8; r++)
          colv[r*64 +: 64] = rows_b[r][c*64 +: 64];
        exp_b_q.push_back(colv);
        exp_b_last_q.push_back((b == 99) && (c == 7));
      end
      for (int r = 0; r < 8; r++) begin
        in_b   = rows_b[r];
        vld_b  = 1'b1;
        last_b = (b == 99) && (r == 7);
        @(posedge clk); #1;
        vld_b  = 1'b0;
        last_b = 1'b0;
        in_b   = '0;
        gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    waited = 0;
    while (exp_b_q.size() != 0 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("b_drain", exp_b_q.size(), 0);
    @(posedge clk); #1;
    check("b_busy", busy_b, 1'b0);
    check("b_ferr", ferr_b, 1'b0);
    mon_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
